alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-entry issue slot between decode and the ALU. A decoded operation
//   is accepted over the in* handshake. Its X/Y operands are selected from
//   the register-file reads, the PC or the immediate. The result is held in
//   registers until the ALU side takes it over the out* handshake.
//   Read-after-write hazards against the in-flight result bus stall the
//   decode side, and every stalled cycle is counted in a saturating counter.
//
//   Optional feature macro: FORWARD_EN
//     defined   -> a completed result-bus value (fwdValid=1, fwdPending=0)
//                  bypasses the register-file read of a matching source.
//     undefined -> no bypass. A matching valid result-bus value stalls
//                  issue, just like a pending one.
//
//   Ports
//     clk, reset            rising-edge clock, asynchronous active-high reset
//     inValid / inReady     decode-side handshake
//     inAluOp, inRd         op code and destination, passed through
//     inRs1, inRs2          source register indices
//     inRs1Data, inRs2Data  register-file read data
//     inImm, inPc           immediate and instruction PC
//     inXSel, inYSel        X: 0=rs1 1=pc ; Y: 0=rs2 1=imm
//     fwdValid, fwdPending  result bus: value valid / result still in flight
//     fwdRd, fwdData        result bus destination and value
//     flush                 drop held and incoming operation
//     aluOp, aluX, aluY,    registered operation toward the ALU
//     outRd
//     outValid / outReady   ALU-side handshake
//     stallCount            saturating count of hazard-stall cycles
module alu_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [3:0]        inAluOp,
    input  logic [4:0]        inRs1,
    input  logic [4:0]        inRs2,
    input  logic [4:0]        inRd,
    input  logic [DATA_W-1:0] inRs1Data,
    input  logic [DATA_W-1:0] inRs2Data,
    input  logic [DATA_W-1:0] inImm,
    input  logic [DATA_W-1:0] inPc,
    input  logic              inXSel,
    input  logic              inYSel,
    input  logic              fwdValid,
    input  logic              fwdPending,
    input  logic [4:0]        fwdRd,
    input  logic [DATA_W-1:0] fwdData,
    input  logic              flush,
    output logic [3:0]        aluOp,
    output logic [DATA_W-1:0] aluX,
    output logic [DATA_W-1:0] aluY,
    output logic [4:0]        outRd,
    output logic              outValid,
    input  logic              outReady,
    output logic [15:0]       stallCount
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]        state_p1;
    logic [1:0]        state_nxt;
    logic [3:0]        op_p1;
    logic [4:0]        rd_p1;
    logic [DATA_W-1:0] x_p1;
    logic [DATA_W-1:0] y_p1;
    logic [15:0]       stall_p1;

    // Register x0 is hard-wired, so index 0 never hazards or forwards.
    logic use_rs1, use_rs2, hit_rs1, hit_rs2;
    logic hazard, capture;
    logic [DATA_W-1:0] src_x, src_y;

    assign use_rs1 = !inXSel && (inRs1 != 5'd0);
    assign use_rs2 = !inYSel && (inRs2 != 5'd0);
    assign hit_rs1 = use_rs1 && (fwdRd == inRs1);
    assign hit_rs2 = use_rs2 && (fwdRd == inRs2);

`ifdef FORWARD_EN
    logic fwd_ok;
    assign fwd_ok = fwdValid && !fwdPending;
    assign hazard = fwdPending && (hit_rs1 || hit_rs2);
    assign src_x  = (fwd_ok && hit_rs1) ? fwdData : inRs1Data;
    assign src_y  = (fwd_ok && hit_rs2) ? fwdData : inRs2Data;
`else
    // Without a bypass, a finished-but-unwritten result is just as stale.
    logic [DATA_W-1:0] unused_fwd_data;
    assign unused_fwd_data = fwdData;
    assign hazard = (fwdPending || fwdValid) && (hit_rs1 || hit_rs2);
    assign src_x  = inRs1Data;
    assign src_y  = inRs2Data;
`endif

    assign inReady = !hazard && !flush && ((state_p1 != ST_FULL) || outReady);
    assign capture = inValid && inReady;

    always_comb begin
        state_nxt = state_p1;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (capture) begin
            state_nxt = ST_FULL;
        end else if ((state_p1 == ST_FULL) && !outReady) begin
            state_nxt = ST_FULL;
        end else if (inValid && hazard) begin
            state_nxt = ST_WAIT;
        end else begin
            state_nxt = ST_EMPTY;
        end
    end

    // ---- stage p1: operand registers toward the ALU ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1 <= ST_EMPTY;
            op_p1    <= 4'd0;
            rd_p1    <= 5'd0;
            x_p1     <= '0;
            y_p1     <= '0;
            stall_p1 <= 16'd0;
        end else begin
            state_p1 <= state_nxt;
            if (capture) begin
                op_p1 <= inAluOp;
                rd_p1 <= inRd;
                x_p1  <= inXSel ? inPc  : src_x;
                y_p1  <= inYSel ? inImm : src_y;
            end
            if (inValid && hazard) begin
                stall_p1 <= sat_inc(stall_p1);
            end
        end
    end

    assign outValid   = (state_p1 == ST_FULL);
    assign aluOp      = op_p1;
    assign outRd      = rd_p1;
    assign aluX       = x_p1;
    assign aluY       = y_p1;
    assign stallCount = stall_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inAluOp;
    logic [4:0]  inRs1, inRs2, inRd;
    logic [31:0] inRs1Data, inRs2Data, inImm, inPc;
    logic        inXSel, inYSel;
    logic        fwdValid, fwdPending;
    logic [4:0]  fwdRd;
    logic [31:0] fwdData;
    logic        flush;
    logic [3:0]  aluOp;
    logic [31:0] aluX, aluY;
    logic [4:0]  outRd;
    logic        outValid;
    logic        outReady;
    logic [15:0] stallCount;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady),
        .inAluOp(inAluOp), .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd),
        .inRs1Data(inRs1Data), .inRs2Data(inRs2Data), .inImm(inImm), .inPc(inPc),
        .inXSel(inXSel), .inYSel(inYSel),
        .fwdValid(fwdValid), .fwdPending(fwdPending), .fwdRd(fwdRd), .fwdData(fwdData),
        .flush(flush),
        .aluOp(aluOp), .aluX(aluX), .aluY(aluY), .outRd(outRd),
        .outValid(outValid), .outReady(outReady),
        .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        xsel, ysel;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [3:0]  op;
        logic        fpend;
        logic [4:0]  frd;
        logic [31:0] ex, ey;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inValid = 0; inAluOp = 0; inRs1 = 0; inRs2 = 0; inRd = 0;
        inRs1Data = 0; inRs2Data = 0; inImm = 0; inPc = 0;
        inXSel = 0; inYSel = 0;
        fwdValid = 0; fwdPending = 0; fwdRd = 0; fwdData = 0;
        flush = 0; outReady = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd);
        inValid = 1; inAluOp = op; inRs1 = rs1; inRs2 = rs2;
        inRs1Data = d1; inRs2Data = d2; inRd = rd; inXSel = 0; inYSel = 0;
    endtask

    initial begin
        //            xsel ysel rs1 rs2 rd  d1            d2            imm           pc            op    fpend frd ex            ey
        vecs[0] = '{1'b0, 1'b0, 5'd1, 5'd2, 5'd1,  32'd5,        32'd7,        32'd0,        32'd0,        4'h0, 1'b0, 5'd0, 32'd5,        32'd7};
        vecs[1] = '{1'b1, 1'b1, 5'd3, 5'd4, 5'd9,  32'd11,       32'd22,       32'h100,      32'h1000,     4'hA, 1'b0, 5'd0, 32'h1000,     32'h100};
        vecs[2] = '{1'b0, 1'b1, 5'd5, 5'd6, 5'd31, 32'hFFFFFFFF, 32'd3,        32'h80000000, 32'd4,        4'hF, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h80000000};
        vecs[3] = '{1'b1, 1'b0, 5'd7, 5'd8, 5'd0,  32'd9,        32'hCAFEF00D, 32'd1,        32'h12345678, 4'h3, 1'b0, 5'd0, 32'h12345678, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd2,  32'h55,       32'hAA,       32'd0,        32'd0,        4'h5, 1'b0, 5'd0, 32'h55,       32'hAA};
        vecs[5] = '{1'b0, 1'b0, 5'd3, 5'd5, 5'd4,  32'h10,       32'h20,       32'd0,        32'd0,        4'h6, 1'b1, 5'd7, 32'h10,       32'h20};
        vecs[6] = '{1'b0, 1'b1, 5'd0, 5'd9, 5'd6,  32'h77,       32'h88,       32'h99,       32'd0,        4'h7, 1'b1, 5'd0, 32'h77,       32'h99};

        idle();
        reset = 1;
        #2;
        // reset state
        chk("rst_outValid", outValid, 0);
        chk("rst_aluOp", aluOp, 0);
        chk("rst_aluX", aluX, 0);
        chk("rst_aluY", aluY, 0);
        chk("rst_outRd", outRd, 0);
        chk("rst_stall", stallCount, 0);
        chk("rst_inReady", inReady, 1);
        tick();
        reset = 0;
        #1;

        // table-driven single-op captures
        for (int i = 0; i < 7; i++) begin
            inValid = 1; inXSel = vecs[i].xsel; inYSel = vecs[i].ysel;
            inRs1 = vecs[i].rs1; inRs2 = vecs[i].rs2; inRd = vecs[i].rd;
            inRs1Data = vecs[i].d1; inRs2Data = vecs[i].d2;
            inImm = vecs[i].imm; inPc = vecs[i].pc; inAluOp = vecs[i].op;
            fwdPending = vecs[i].fpend; fwdRd = vecs[i].frd;
            #1;
            chk($sformatf("v%0d_inReady", i), inReady, 1);
            tick();
            inValid = 0; fwdPending = 0;
            chk($sformatf("v%0d_outValid", i), outValid, 1);
            chk($sformatf("v%0d_aluX", i), aluX, vecs[i].ex);
            chk($sformatf("v%0d_aluY", i), aluY, vecs[i].ey);
            chk($sformatf("v%0d_aluOp", i), aluOp, vecs[i].op);
            chk($sformatf("v%0d_outRd", i), outRd, vecs[i].rd);
            tick();
            chk($sformatf("v%0d_drain", i), outValid, 0);
        end
        chk("no_stall_so_far", stallCount, 0);

        // result-bus value on rs1
        idle();
        drive_op(4'h1, 5'd3, 5'd0, 32'd1, 32'd0, 5'd2);
        fwdValid = 1; fwdRd = 5'd3; fwdData = 32'hDEADBEEF;
        #1;
`ifdef FORWARD_EN
        chk("fwd_inReady", inReady, 1);
        tick();
        chk("fwd_aluX", aluX, 32'hDEADBEEF);
        // both sources match: both take the bypass
        drive_op(4'h2, 5'd6, 5'd6, 32'd1, 32'd2, 5'd2);
        fwdRd = 5'd6; fwdData = 32'h0BADF00D;
        tick();
        chk("fwd_both_x", aluX, 32'h0BADF00D);
        chk("fwd_both_y", aluY, 32'h0BADF00D);
        inValid = 0;
        tick();
`else
        chk("nofwd_inReady", inReady, 0);
        tick();
        chk("nofwd_wait_outValid", outValid, 0);
        chk("nofwd_stall", stallCount, 1);
        fwdValid = 0;
        tick();
        chk("nofwd_aluX", aluX, 32'd1);
        inValid = 0;
        tick();
`endif
        // rs1 index 0 is never bypassed
        drive_op(4'h1, 5'd0, 5'd0, 32'd1, 32'd0, 5'd2);
        fwdValid = 1; fwdRd = 5'd0; fwdData = 32'hDEADBEEF;
        #1;
        chk("x0_inReady", inReady, 1);
        tick();
        chk("x0_aluX", aluX, 32'd1);
        idle();
        tick();

        // pending hazard on rs2 for three cycles
        do_reset();
        drive_op(4'h4, 5'd1, 5'd4, 32'd10, 32'd20, 5'd8);
        inImm = 32'h44; fwdPending = 1; fwdRd = 5'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("haz_inReady_c%0d", c), inReady, 0);
            tick();
            chk($sformatf("haz_outValid_c%0d", c), outValid, 0);
        end
        chk("haz_stall3", stallCount, 3);
        inYSel = 1;
        #1;
        chk("haz_ysel_inReady", inReady, 1);
        tick();
        chk("haz_ysel_outValid", outValid, 1);
        chk("haz_ysel_aluY", aluY, 32'h44);
        chk("haz_ysel_stall", stallCount, 3);
        idle();
        tick();

        // back-pressure while a new op waits
        drive_op(4'h8, 5'd1, 5'd2, 32'hA1, 32'hA2, 5'd10);
        tick();
        outReady = 0;
        drive_op(4'h9, 5'd3, 5'd4, 32'hB1, 32'hB2, 5'd11);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp_inReady_c%0d", c), inReady, 0);
            tick();
            chk($sformatf("bp_outValid_c%0d", c), outValid, 1);
            chk($sformatf("bp_aluX_c%0d", c), aluX, 32'hA1);
            chk($sformatf("bp_aluOp_c%0d", c), aluOp, 4'h8);
        end
        outReady = 1;
        #1;
        chk("bp_release_inReady", inReady, 1);
        tick();
        chk("b2b_outValid", outValid, 1);
        chk("b2b_aluX", aluX, 32'hB1);
        chk("b2b_aluY", aluY, 32'hB2);
        chk("b2b_outRd", outRd, 5'd11);
        inValid = 0;
        tick();
        chk("b2b_drain", outValid, 0);

        // flush against a held op and a new incoming op
        drive_op(4'hC, 5'd1, 5'd2, 32'hC1, 32'hC2, 5'd12);
        tick();
        drive_op(4'hD, 5'd1, 5'd2, 32'hD1, 32'hD2, 5'd13);
        outReady = 1; flush = 1;
        #1;
        chk("flush_inReady", inReady, 0);
        tick();
        flush = 0; inValid = 0;
        chk("flush_outValid", outValid, 0);
        chk("flush_aluX_kept", aluX, 32'hC1);
        chk("flush_stall_kept", stallCount, 3);
        tick();
        chk("flush_stays_empty", outValid, 0);

        // asynchronous reset while FULL
        drive_op(4'hE, 5'd1, 5'd2, 32'hE1, 32'hE2, 5'd14);
        tick();
        inValid = 0; outReady = 0;
        chk("prereset_full", outValid, 1);
        #2;
        reset = 1;
        #1;
        chk("async_rst_outValid", outValid, 0);
        chk("async_rst_aluX", aluX, 0);
        chk("async_rst_stall", stallCount, 0);
        tick();
        reset = 0;
        idle();
        #1;

        // stall counter saturation
        drive_op(4'h0, 5'd1, 5'd4, 32'd0, 32'd0, 5'd1);
        fwdPending = 1; fwdRd = 5'd4;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", stallCount, 16'hFFFE);
        tick();
        chk("sat_ffff", stallCount, 16'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        chk("sat_hold", stallCount, 16'hFFFF);
        chk("sat_no_capture", outValid, 0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
